// File: rtl/draw_source_scheduler.sv
// -----------------------------------------------------------------------------
// draw_source_scheduler
//
// Per-frame sequencer for the shared frame-manager write bus. On every accepted
// frame_start the bus is granted, one after the other, to each enabled draw
// source in ascending ID order (painter's order: later sources overwrite
// earlier ones). A watchdog skips any source that never starts drawing or
// never finishes. After the last index a buffer swap is requested, and
// frame_done pulses once the swap is acknowledged.
//
// Ports:
//   clk              in   system clock, rising edge
//   resetN           in   asynchronous active-low reset
//   frame_start      in   single-cycle pulse, starts a frame schedule
//   source_enable    in   per-source enable, latched when a frame is accepted
//   write_active     in   shared bus line driven by the selected source
//   swap_ack         in   frame manager accepted the buffer swap
//   err_clear        in   clears timeout_err and overrun
//   write_source_sel out  ID of the source owning the bus
//   write_awaited    out  draw request to the selected source
//   swap_req         out  buffer swap request (level)
//   frame_done       out  one-cycle pulse when the frame is complete
//   busy             out  high whenever the scheduler is not idle
//   timeout_err      out  sticky per-source watchdog error
//   overrun          out  sticky, frame_start arrived while busy
// -----------------------------------------------------------------------------
module draw_source_scheduler #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 2,
    parameter int START_TIMEOUT    = 16,
    parameter int RUN_TIMEOUT      = 524288,
    parameter int CNT_W            = 20
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        frame_start,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    input  logic                        write_active,
    input  logic                        swap_ack,
    input  logic                        err_clear,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    output logic                        swap_req,
    output logic                        frame_done,
    output logic                        busy,
    output logic [NUM_SOURCES-1:0]      timeout_err,
    output logic                        overrun
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_GRANT   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_ADVANCE = 3'd4;
    localparam logic [2:0] ST_SWAP    = 3'd5;

    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX   = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    localparam logic [CNT_W-1:0]            START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]            RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);

    logic [2:0]                  state_r;
    logic [SOURCE_SEL_ADDRW-1:0] idx_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [NUM_SOURCES-1:0]      en_q_r;
    logic                        start_q_r;

    logic [2:0]                  state_s;
    logic [SOURCE_SEL_ADDRW-1:0] idx_s;
    logic [CNT_W-1:0]            cnt_s;
    logic [SOURCE_SEL_ADDRW-1:0] sel_s;
    logic                        awaited_s;
    logic                        swap_s;
    logic                        done_s;
    logic [NUM_SOURCES-1:0]      tmo_set_s;
    logic                        active_s;
    logic                        accept_s;
    logic                        overrun_evt_s;

    // Only a solid 1 counts as drawing; a floating or unknown bus line is idle.
    assign active_s = (write_active === 1'b1);

    // A start is accepted only when idle and no start is already pending; any
    // other start pulse is an overrun and never disturbs the running schedule.
    assign accept_s      = frame_start & ~busy & ~start_q_r;
    assign overrun_evt_s = frame_start & (busy | start_q_r);

    // Next-state and next-output computation for the scheduling FSM.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        sel_s     = write_source_sel;
        awaited_s = write_awaited;
        swap_s    = swap_req;
        done_s    = 1'b0;
        tmo_set_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start_q_r) begin
                    idx_s   = '0;
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // The bus owner only changes here, never while a source draws.
                if (en_q_r[idx_r]) begin
                    sel_s     = idx_r;
                    awaited_s = 1'b1;
                    cnt_s     = '0;
                    state_s   = ST_GRANT;
                end else begin
                    state_s   = ST_ADVANCE;
                end
            end
            ST_GRANT: begin
                if (active_s) begin
                    awaited_s = 1'b0;
                    cnt_s     = '0;
                    state_s   = ST_RUN;
                end else if (cnt_r == START_LAST) begin
                    awaited_s        = 1'b0;
                    tmo_set_s[idx_r] = 1'b1;
                    state_s          = ST_ADVANCE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // write_awaited stays low so a finished source does not restart.
                if (!active_s) begin
                    state_s = ST_ADVANCE;
                end else if (cnt_r == RUN_LAST) begin
                    tmo_set_s[idx_r] = 1'b1;
                    state_s          = ST_ADVANCE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_ADVANCE: begin
                if (idx_r == LAST_IDX) begin
                    swap_s  = 1'b1;
                    state_s = ST_SWAP;
                end else begin
                    idx_s   = idx_r + SOURCE_SEL_ADDRW'(1);
                    state_s = ST_SELECT;
                end
            end
            ST_SWAP: begin
                if (swap_ack == 1'b1) begin
                    swap_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    swap_s  = 1'b1;
                end
            end
            default: begin
                awaited_s = 1'b0;
                swap_s    = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r          <= ST_IDLE;
            idx_r            <= '0;
            cnt_r            <= '0;
            en_q_r           <= '0;
            start_q_r        <= 1'b0;
            write_source_sel <= '0;
            write_awaited    <= 1'b0;
            swap_req         <= 1'b0;
            frame_done       <= 1'b0;
            busy             <= 1'b0;
            timeout_err      <= '0;
            overrun          <= 1'b0;
        end else begin
            state_r          <= state_s;
            idx_r            <= idx_s;
            cnt_r            <= cnt_s;
            start_q_r        <= accept_s;
            write_source_sel <= sel_s;
            write_awaited    <= awaited_s;
            swap_req         <= swap_s;
            frame_done       <= done_s;
            busy             <= (state_s != ST_IDLE);
            if (accept_s) begin
                en_q_r <= source_enable;
            end else begin
                en_q_r <= en_q_r;
            end
            // Clearing wins over a same-cycle error event.
            if (err_clear) begin
                timeout_err <= '0;
                overrun     <= 1'b0;
            end else begin
                timeout_err <= timeout_err | tmo_set_s;
                overrun     <= overrun | overrun_evt_s;
            end
        end
    end

endmodule
